// File: rtl/and4_selftest_seq.sv
// Built-in self-test sequencer for a 4-input AND gate.
// It walks vec = {a,b,c,d} from 0 to 15, holds each vector SETTLE_CYCLES clocks, then samples f against &vec.
module and4_selftest_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       drive, drive_nxt;
  logic             busy_nxt, done_nxt, pass_nxt, ffv_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [3:0]       ffvec_nxt;
  logic             mismatch;

  assign {a, b, c, d} = drive;

  // An unknown f fails the equality test and falls through as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (f == &vec) mismatch = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err_count;
    ffv_nxt   = first_fail_valid;
    ffvec_nxt = first_fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SETTLE;
          vec_nxt   = 4'h0;
          cnt_nxt   = '0;
          err_nxt   = '0;
          ffv_nxt   = 1'b0;
          ffvec_nxt = 4'h0;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_nxt = err_count + 1'b1;
          if (!first_fail_valid) begin
            ffv_nxt   = 1'b1;
            ffvec_nxt = vec;
          end
        end
        if (vec == 4'hF) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          vec_nxt   = vec + 4'd1;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are registered, so they are computed from the next-state values.
    drive_nxt = (state_nxt == SETTLE || state_nxt == SAMPLE) ? vec_nxt : 4'h0;
    pass_nxt  = done_nxt && (err_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= 4'h0;
      cnt              <= '0;
      drive            <= 4'h0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 4'h0;
    end else begin
      state            <= state_nxt;
      vec              <= vec_nxt;
      cnt              <= cnt_nxt;
      drive            <= drive_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      err_count        <= err_nxt;
      first_fail_valid <= ffv_nxt;
      first_fail_vec   <= ffvec_nxt;
    end
  end

endmodule

// File: tb/tb_and4_selftest_seq.sv
// Scoreboard bench for and4_selftest_seq: two instances (default, and ERR_W=3/SETTLE_CYCLES=1)
// test a gate model described by a 16-entry truth table. The table can be good, stuck, or random.
module tb_and4_selftest_seq;

  localparam int NI  = 2;
  localparam int SC0 = 2;
  localparam int EW0 = 5;
  localparam int SC1 = 1;
  localparam int EW1 = 3;

  typedef struct {
    int unsigned err;
    bit          ffv;
    int unsigned ffvec;
    bit          pass;
    longint      done_cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] truth = 16'h8000;

  logic           f0, a0, b0, c0, d0, busy0, done0, pass0, ffv0;
  logic [EW0-1:0] err0;
  logic [3:0]     ffvec0;
  logic           f1, a1, b1, c1, d1, busy1, done1, pass1, ffv1;
  logic [EW1-1:0] err1;
  logic [3:0]     ffvec1;

  logic [3:0] vec_o   [NI];
  logic       busy_o  [NI];
  logic       done_o  [NI];
  logic       pass_o  [NI];
  logic       ffv_o   [NI];
  logic [3:0] ffvec_o [NI];
  logic [4:0] err_o   [NI];

  longint cyc = 0;
  longint last_start = 0;
  int     errors = 0;
  int     checks = 0;
  exp_t   sb0[$];
  exp_t   sb1[$];

  and4_selftest_seq #(.SETTLE_CYCLES(SC0), .ERR_W(EW0)) dut (
    .clk(clk), .rst(rst), .start(start), .f(f0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  and4_selftest_seq #(.SETTLE_CYCLES(SC1), .ERR_W(EW1)) dut_w3 (
    .clk(clk), .rst(rst), .start(start), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  assign f0 = truth[{a0, b0, c0, d0}];
  assign f1 = truth[{a1, b1, c1, d1}];

  assign vec_o[0]   = {a0, b0, c0, d0};
  assign vec_o[1]   = {a1, b1, c1, d1};
  assign busy_o[0]  = busy0;
  assign busy_o[1]  = busy1;
  assign done_o[0]  = done0;
  assign done_o[1]  = done1;
  assign pass_o[0]  = pass0;
  assign pass_o[1]  = pass1;
  assign ffv_o[0]   = ffv0;
  assign ffv_o[1]   = ffv1;
  assign ffvec_o[0] = ffvec0;
  assign ffvec_o[1] = ffvec1;
  assign err_o[0]   = err0;
  assign err_o[1]   = {2'b00, err1};

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference result of a whole pass, derived from the gate's truth table alone.
  function automatic exp_t model(input logic [15:0] tt, input int ew, input int sc, input longint s_edge);
    exp_t e;
    int   errs;
    bit   good;
    errs    = 0;
    e.ffv   = 1'b0;
    e.ffvec = 0;
    for (int v = 0; v < 16; v++) begin
      good = (v == 15);
      if (tt[v] != good) begin
        errs++;
        if (!e.ffv) begin
          e.ffv   = 1'b1;
          e.ffvec = v;
        end
      end
    end
    e.err      = (errs > (1 << ew) - 1) ? (1 << ew) - 1 : errs;
    e.pass     = (errs == 0);
    e.done_cyc = s_edge + 16 * (sc + 1);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int inst, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0d expected %0d", name, inst, actual, expected);
    end
  endtask

  task automatic checkReset();
    for (int i = 0; i < NI; i++)
      checkOutput("reset_outputs", i,
        {vec_o[i], busy_o[i], done_o[i], pass_o[i], ffv_o[i], ffvec_o[i], err_o[i]}, 0);
  endtask

  task automatic applyStimulus(input logic [15:0] tt);
    @(negedge clk);
    truth = tt;
    start = 1'b1;
    last_start = cyc + 1;
    sb0.push_back(model(tt, EW0, SC0, last_start));
    sb1.push_back(model(tt, EW1, SC1, last_start));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checkOutput("busy_after_start", i, busy_o[i], 1);
      checkOutput("done_after_start", i, done_o[i], 0);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles expected done", budget);
      sb0.delete();
      sb1.delete();
    end
  endtask

  // Monitor: records the vector walk while busy and scores each rising done.
  bit         busy_q    [NI] = '{default: 1'b0};
  bit         done_q    [NI] = '{default: 1'b0};
  int         walk_cnt  [NI] = '{default: 0};
  int         walk_bad  [NI] = '{default: 0};
  logic [3:0] walk_last [NI] = '{default: 4'h0};

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < NI; i++) begin
      if (busy_o[i] && !busy_q[i]) begin
        walk_cnt[i] = 0;
        walk_bad[i] = 0;
      end
      if (busy_o[i] && (walk_cnt[i] == 0 || vec_o[i] != walk_last[i])) begin
        if (int'(vec_o[i]) != walk_cnt[i]) walk_bad[i]++;
        walk_cnt[i]++;
        walk_last[i] = vec_o[i];
      end
      if (done_o[i] && !done_q[i]) begin
        have = 1'b0;
        if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done inst%0d: got done=1 expected no pass pending", i);
        end else begin
          checkOutput("done_cycle", i, cyc, e.done_cyc);
          checkOutput("err_count", i, err_o[i], e.err);
          checkOutput("first_fail_valid", i, ffv_o[i], e.ffv);
          checkOutput("first_fail_vec", i, ffvec_o[i], e.ffvec);
          checkOutput("pass", i, pass_o[i], e.pass);
          checkOutput("busy_at_done", i, busy_o[i], 0);
          checkOutput("vec_at_done", i, vec_o[i], 0);
          checkOutput("walk_len", i, walk_cnt[i], 16);
          checkOutput("walk_order_errs", i, walk_bad[i], 0);
        end
      end
      busy_q[i] = busy_o[i];
      done_q[i] = done_o[i];
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkReset();
    rst = 1'b0;

    $display("[TB] good gate, stuck-at-0, stuck-at-1");
    applyStimulus(16'h8000); waitIdle(300);
    applyStimulus(16'h0000); waitIdle(300);
    applyStimulus(16'hFFFF); waitIdle(300);

    $display("[TB] random gate faults");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(16'($urandom));
      waitIdle(300);
    end

    $display("[TB] reset in the middle of a pass");
    applyStimulus(16'($urandom));
    while (cyc < last_start + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb0.delete();
    sb1.delete();
    checkReset();
    rst = 1'b0;
    applyStimulus(16'h8000); waitIdle(300);

    $display("[TB] start while busy, then start while done");
    applyStimulus(16'h0000);
    while (cyc < last_start + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(300);
    applyStimulus(16'($urandom) | 16'h0001);
    waitIdle(300);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
